// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the fetch/decode slice.
// Provides datapath width, the canonical bubble instruction (addi x0,x0,0),
// register-field positions inside an instruction word and the default reset PC.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;

  // addi x0, x0, 0 : rs1 = rs2 = x0, so a bubble never matches a real rd
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Byte increment between sequential instructions
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_decode_stage_pc_register.sv
// Program-counter flop for the fetch stage.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-low; loads RESET_PC
//   en   - load enable; q holds when low
//   d    - next PC
//   q    - current PC (PC_F)
module pc_register #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  // PC state with synchronous reset and load enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// IF stage plus IF/ID pipeline register for the 5-stage RV32I pipeline.
// Holds PC_F, drives the instruction-memory address, and registers the fetched
// instruction into the decode stage under hazard-unit stall/flush control.
// Ports:
//   clk, rst                  - clock (rising edge), synchronous active-low reset
//   Stall_F / Stall_D         - hold PC_F / hold the IF/ID register
//   Flush_D                   - replace IF/ID contents with a bubble
//   PCSrc_E, PCTarget_E       - branch/jump redirect from execute
//   imem_addr, imem_rdata     - async instruction ROM interface (imem_addr = PC_F)
//   Instr_D, PC_D, PCPlus4_D, Valid_D - decode-stage registers
//   Rs1_D, Rs2_D              - source register fields of Instr_D, to hazard unit
//   stall_cycles, flush_cycles - saturating perf counters
// Configuration macro: FETCH_PERF_EN adds the CNT_W parameter, the two counter
// ports and their logic; without it they are absent.
module fetch_decode_stage #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::DEFAULT_RESET_PC
`ifdef FETCH_PERF_EN
  ,
  parameter int unsigned     CNT_W    = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall_F,
  input  logic             Stall_D,
  input  logic             Flush_D,
  input  logic             PCSrc_E,
  input  logic [XLEN-1:0]  PCTarget_E,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instr_D,
  output logic [XLEN-1:0]  PC_D,
  output logic [XLEN-1:0]  PCPlus4_D,
  output logic             Valid_D,
  output logic [4:0]       Rs1_D,
  output logic [4:0]       Rs2_D
`ifdef FETCH_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
`endif
);

  import riscv_pkg::*;

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] pc_next;
  logic            pc_en;

  // Sequential PC wraps naturally at XLEN bits
  assign pc_plus4_f = pc_f + XLEN'(INSTR_BYTES);

  // A redirect must land even during a load-use stall, otherwise the
  // wrong-path fetch would be held instead of discarded
  assign pc_next = PCSrc_E ? PCTarget_E : pc_plus4_f;
  assign pc_en   = PCSrc_E | ~Stall_F;

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_next),
    .q   (pc_f)
  );

  assign imem_addr = pc_f;

  // IF/ID register: flush beats stall so a squashed slot never survives
  always_ff @(posedge clk) begin
    if (!rst || Flush_D) begin
      Instr_D   <= NOP_INSTR;
      PC_D      <= '0;
      PCPlus4_D <= '0;
      Valid_D   <= 1'b0;
    end else if (!Stall_D) begin
      Instr_D   <= imem_rdata;
      PC_D      <= pc_f;
      PCPlus4_D <= pc_plus4_f;
      Valid_D   <= 1'b1;
    end
  end

  // Source fields for the hazard unit, decoded straight off the register
  assign Rs1_D = Instr_D[RS1_LSB +: REG_ADDR_W];
  assign Rs2_D = Instr_D[RS2_LSB +: REG_ADDR_W];

`ifdef FETCH_PERF_EN
  // Saturating stall/flush event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (Stall_F && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (Flush_D && (flush_cycles != '1)) begin
        flush_cycles <= flush_cycles + CNT_W'(1);
      end
    end
  end
`endif

endmodule
